// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port game-grid RAM between the VGA pixel
// fetch (strict priority) and the snake game logic (request/grant), with a
// starvation guard that forces a game slot after STARVE_LIMIT denied cycles.
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic              disp_miss,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic [DATA_W-1:0] game_rdata,
    output logic              game_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       miss_cnt
);

    // Who owns the RAM read data arriving next cycle.
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_GRD} owner_t;

    localparam logic [15:0] LIMIT    = 16'(STARVE_LIMIT);
    localparam bit          FORCE_EN = (STARVE_LIMIT != 0);

    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic        r_disp_miss;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_live_cnt;
    logic [15:0] r_miss_cnt;
    logic        w_force;
    logic        w_disp_slot;
    logic        w_game_slot;
    logic [15:0] w_live_inc;

    // Slot decision: forced game beats display, display beats normal game.
    always_comb begin
        w_force     = game_req && FORCE_EN && (r_wait_cnt >= LIMIT);
        w_disp_slot = !w_force && disp_req;
        w_game_slot = w_force || (!disp_req && game_req);
    end

    // Return-owner register; also registers the dropped-display flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_NONE;
            r_disp_miss <= 1'b0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_disp_miss <= w_force && disp_req;
        end
    end

    // Next owner: game writes return nothing.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_disp_slot)
            w_owner_nxt = OWN_DISP;
        else if (w_game_slot && !game_we)
            w_owner_nxt = OWN_GRD;
    end

    // RAM port drive and read-return steering from the current slot/owner.
    always_comb begin
        ram_en      = w_disp_slot || w_game_slot;
        ram_we      = w_game_slot && game_we;
        ram_addr    = w_game_slot ? game_addr : disp_addr;
        ram_wdata   = game_wdata;
        game_gnt    = w_game_slot;
        disp_rvalid = (r_owner == OWN_DISP);
        game_rvalid = (r_owner == OWN_GRD);
        disp_rdata  = disp_rvalid ? ram_rdata : '0;
        game_rdata  = game_rvalid ? ram_rdata : '0;
        disp_miss   = r_disp_miss;
        miss_cnt    = r_miss_cnt;
    end

    // Saturating count of consecutive denied game cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wait_cnt <= '0;
        else if (!game_req || w_game_slot)
            r_wait_cnt <= '0;
        else if (r_wait_cnt != 16'hFFFF)
            r_wait_cnt <= r_wait_cnt + 16'd1;
    end

    assign w_live_inc = (r_live_cnt == 16'hFFFF) ? r_live_cnt : r_live_cnt + 16'd1;

    // Per-frame miss counting; a miss pulsing on frame_start belongs to the closing frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live_cnt <= '0;
            r_miss_cnt <= '0;
        end else if (frame_start) begin
            r_miss_cnt <= r_disp_miss ? w_live_inc : r_live_cnt;
            r_live_cnt <= '0;
        end else if (r_disp_miss) begin
            r_live_cnt <= w_live_inc;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a behavioural RAM on the RAM port, a reference model
// of the arbitration rules with a shadow copy of RAM contents, directed steps
// from the test plan followed by protocol-respecting random traffic.
module tb_vram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 4;
    localparam int LIM    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              disp_miss;
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_gnt;
    logic [DATA_W-1:0] game_rdata;
    logic              game_rvalid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [15:0]       miss_cnt;
    logic              ram_init;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
        .disp_rvalid(disp_rvalid), .disp_miss(disp_miss),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rdata(game_rdata),
        .game_rvalid(game_rvalid), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle read latency; preloaded with addr+5.
    logic [DATA_W-1:0] mem [2048];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 4'(i + 5);
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DATA_W-1:0] sh [2048];
    int   m_wait, m_live, m_mcnt;
    bit   m_pd, m_pg, m_pm;
    logic [DATA_W-1:0] m_dd, m_gd;

    // Samples from the most recent cycle
    logic s_gnt, s_miss, s_drv, s_grv, s_we;
    logic [DATA_W-1:0] s_drd, s_grd;
    logic [ADDR_W-1:0] s_addr;
    logic [15:0] s_mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_live = 0; m_mcnt = 0;
        m_pd = 0; m_pg = 0; m_pm = 0; m_dd = '0; m_gd = '0;
    endtask

    // One clock cycle: drive, check at negedge, advance model, return at posedge+1.
    task automatic cyc(input bit dq, input int da, input bit gq, input bit gw,
                       input int ga, input int gd, input bit fs);
        bit frc, ds, gs, cur_miss;
        disp_req = dq; disp_addr = 11'(da);
        game_req = gq; game_we = gw; game_addr = 11'(ga); game_wdata = 4'(gd);
        frame_start = fs;
        @(negedge clk);
        frc = gq && (LIM != 0) && (m_wait >= LIM);
        ds  = !frc && dq;
        gs  = frc || (!dq && gq);
        chk("ram_en", ram_en, ds || gs);
        chk("ram_we", ram_we, gs && gw);
        chk("game_gnt", game_gnt, gs);
        if (ds) chk("ram_addr_disp", ram_addr, da);
        if (gs) begin
            chk("ram_addr_game", ram_addr, ga);
            if (gw) chk("ram_wdata", ram_wdata, gd);
        end
        chk("disp_rvalid", disp_rvalid, m_pd);
        chk("disp_rdata", disp_rdata, m_pd ? m_dd : 4'h0);
        chk("game_rvalid", game_rvalid, m_pg);
        chk("game_rdata", game_rdata, m_pg ? m_gd : 4'h0);
        chk("disp_miss", disp_miss, m_pm);
        chk("miss_cnt", miss_cnt, m_mcnt);
        s_gnt = game_gnt; s_miss = disp_miss; s_drv = disp_rvalid; s_grv = game_rvalid;
        s_drd = disp_rdata; s_grd = game_rdata; s_addr = ram_addr; s_we = ram_we;
        s_mcnt = miss_cnt;
        cur_miss = m_pm;
        m_pd = ds;
        if (ds) m_dd = sh[da];
        m_pg = gs && !gw;
        if (m_pg) m_gd = sh[ga];
        if (gs && gw) sh[ga] = 4'(gd);
        m_pm = frc && dq;
        m_wait = (gq && !gs) ? ((m_wait < 65535) ? m_wait + 1 : m_wait) : 0;
        if (fs) begin
            m_mcnt = (m_live + int'(cur_miss) > 65535) ? 65535 : m_live + int'(cur_miss);
            m_live = 0;
        end else if (cur_miss) begin
            m_live = (m_live < 65535) ? m_live + 1 : m_live;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    bit hq, hw, dq, fs;
    int ha, hd, da;

    initial begin
        rst_n = 0; ram_init = 1;
        frame_start = 0; disp_req = 0; disp_addr = '0;
        game_req = 0; game_we = 0; game_addr = '0; game_wdata = '0;
        for (int i = 0; i < 2048; i++) sh[i] = 4'(i + 5);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        ram_init = 0;
        // Reset state
        chk("rst_ram_en", ram_en, 0);
        chk("rst_gnt", game_gnt, 0);
        chk("rst_drv", disp_rvalid, 0);
        chk("rst_grv", game_rvalid, 0);
        chk("rst_miss", disp_miss, 0);
        chk("rst_mcnt", miss_cnt, 0);
        rst_n = 1;
        idle();

        // Display only
        cyc(1, 5, 0, 0, 0, 0, 0);
        chk("dsp_addr", s_addr, 11'h005);
        idle();
        chk("dsp_rvalid", s_drv, 1);
        chk("dsp_rdata", s_drd, 4'hA);

        // Contention, then game write wins the free cycle
        cyc(1, 7, 1, 1, 16, 3, 0);
        chk("cont_gnt0", s_gnt, 0);
        cyc(0, 0, 1, 1, 16, 3, 0);
        chk("cont_gnt1", s_gnt, 1);
        chk("cont_we", s_we, 1);
        chk("cont_addr", s_addr, 11'h010);
        chk("cont_drv", s_drv, 1);

        // Game read of what was just written
        cyc(0, 0, 1, 0, 16, 0, 0);
        idle();
        chk("grd_rvalid", s_grv, 1);
        chk("grd_rdata", s_grd, 4'h3);
        chk("grd_drv", s_drv, 0);

        // Async reset while a display read is in flight
        cyc(1, 9, 0, 0, 0, 0, 0);
        disp_req = 0;
        #2 rst_n = 0;
        #1;
        chk("mrst_drv", disp_rvalid, 0);
        chk("mrst_drd", disp_rdata, 0);
        chk("mrst_en", ram_en, 0);
        chk("mrst_gnt", game_gnt, 0);
        chk("mrst_mcnt", miss_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        idle();
        chk("mrst_norv", s_drv, 0);

        // Starvation: grant on the 9th cycle, miss flagged on the 10th
        for (int k = 1; k <= 9; k++) begin
            cyc(1, k, 1, 0, 20, 0, 0);
            chk("starve_gnt", s_gnt, (k == 9));
        end
        idle();
        chk("starve_miss", s_miss, 1);
        chk("starve_drv", s_drv, 0);
        chk("starve_grv", s_grv, 1);

        // Close frame holding one miss, then three misses; 3rd pulses on frame_start
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("frame1_cnt", s_mcnt, 1);
        for (int k = 1; k <= 27; k++) begin
            cyc(1, k, 1, 0, 21, 0, 0);
            chk("miss_gnt", s_gnt, (k % 9 == 0));
        end
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("miss_pulse", s_miss, 1);
        idle();
        chk("frame3_cnt", s_mcnt, 3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("frame0_cnt", s_mcnt, 0);

        // Game drops request before grant
        cyc(1, 1, 1, 1, 22, 9, 0);
        cyc(1, 2, 0, 0, 0, 0, 0);
        chk("drop_gnt", s_gnt, 0);

        // Random traffic; game fields held until granted or dropped
        hq = 0; hw = 0; ha = 0; hd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hq && $urandom_range(0, 15) == 0) hq = 0;
            else if (!hq) begin
                hq = ($urandom_range(0, 2) != 0);
                hw = 1'($urandom_range(0, 1));
                ha = $urandom_range(0, 15);
                hd = $urandom_range(0, 15);
            end
            dq = ($urandom_range(0, 3) != 0);
            da = $urandom_range(0, 31);
            fs = ($urandom_range(0, 40) == 0);
            cyc(dq, da, hq, hw, ha, hd, fs);
            if (s_gnt) hq = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
